dot_prod_engine: RTL and testbench
==================================

// Module: dot_prod_engine
// PURPOSE
//  Responder side of the dotProd start/done + array-load interface: holds two signed
//  operand memories (a, b), lets the host fill/read them while controlArr=1, then on a
//  r_enable pulse computes result = init_acc + sum(a[k]*b[k], k=init_i..N-1) and pulses
//  w_enable. Sits under the `main` top of the generated dotProd design.
// PARAMETERS
//  N     1000  number of array elements; valid addresses 0..N-1
//  AW    10    address width (2**AW >= N)
//  DW    27    signed element width
//  ACCW  64    signed accumulator/result width
// PORTS
//  clk                  in   1     rising-edge clock
//  rst_n                in   1     asynchronous active-low reset
//  r_enable             in   1     start pulse (sampled only in IDLE with controlArr=0)
//  init_i               in   AW    first index, captured at start
//  init_acc             in   ACCW  signed initial accumulator, captured at start
//  w_enable             out  1     done pulse, exactly 1 cycle
//  result               out  ACCW  signed dot product; valid with w_enable, held after
//  controlArr           in   1     1 = host owns memory ports, 0 = engine owns them
//  controlArrWEnable_a  in   1     host write strobe, array a
//  controlArrAddr_a     in   AW    host address, array a
//  controlArrWData_a    in   DW    host write data, array a
//  controlArrRData_a    out  DW    host read data, array a
//  controlArrWEnable_b / controlArrAddr_b / controlArrWData_b / controlArrRData_b: same, array b
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, w_enable=0, result=0, RData_a/b=0, accumulator=0.
//    Memory contents not cleared. Reset mid-computation aborts; no w_enable follows.
//  - Memories: 2**AW x DW each, one port, synchronous write, 1-cycle registered read.
//  - Host access (state IDLE and controlArr=1): write when WEnable=1 at the edge; RData
//    shows mem[Addr] sampled at previous edge (read-before-write on same address).
//    Addresses >= N accepted as ordinary storage, never read by the engine.
//  - Host access while BUSY: writes dropped, RData_a/b driven 0.
//  - FSM: IDLE -> (r_enable & !controlArr) -> RUN -> DRAIN -> DONE -> IDLE.
//    IDLE : capture init_i/init_acc on start; r_enable with controlArr=1 ignored.
//    RUN  : issue one address per cycle, init_i..N-1, both memories in lockstep.
//    DRAIN: flush pipeline until last product accumulated.
//    DONE : w_enable=1 one cycle, result <= accumulator; then IDLE.
//  - r_enable while not IDLE ignored; r_enable held high restarts only after return to IDLE.
//  - K = N - init_i terms. Start edge = cycle 0. w_enable high in cycle K+2 (K+3 with
//    DOTPROD_MUL_PIPE_EN). If init_i >= N: K=0, skip RUN/DRAIN, w_enable in cycle 1,
//    result = init_acc.
//  - Arithmetic: product = a*b full 2*DW signed, sign-extended to ACCW; accumulation wraps
//    modulo 2**ACCW (two's complement), no saturation.
//  - result holds last value until next DONE; reads of memories unaffected by compute.
// CONFIGURATION
//  DOTPROD_MUL_PIPE_EN defined: extra register between multiplier and adder; latency +1
//    cycle (w_enable at K+3); result identical.
//  Undefined: multiply and accumulate in same cycle after read data; w_enable at K+2.
// TESTING
//  1 Load a[k]=k+1, b[k]=2 (k<1000), start init_i=0, init_acc=0 -> w_enable once in cycle
//    1002 (1003 with _EN), result=1001000.
//  2 Random a,b in [-2**26, 2**26-1], init_acc=0 -> result equals 64-bit software sum.
//  3 a=b=-2**26 all entries, init_acc=2**63-1 -> result wraps (mod 2**64) matching model.
//  4 init_i=997, init_acc=5, a[997..999]=3, b=4 -> result=41 at cycle 5; init_i=1000 ->
//    result=init_acc, w_enable in cycle 1.
//  5 Host writes/reads during BUSY -> memory unchanged, RData=0; second r_enable ignored;
//    r_enable with controlArr=1 -> no w_enable.
//  6 rst_n low at cycle 500 of run -> w_enable/result 0 immediately, memories intact;
//    restart gives correct result.

Source files
------------

// File: rtl/dot_prod_if.sv
// Host/engine bundle for dot_prod_engine: start/done handshake plus the two
// array-load ports (a and b). master = host side, slave = engine side.
interface dot_prod_if #(
    parameter int AW   = 10,
    parameter int DW   = 27,
    parameter int ACCW = 64
);
    logic                   r_enable;
    logic [AW-1:0]          init_i;
    logic signed [ACCW-1:0] init_acc;
    logic                   w_enable;
    logic signed [ACCW-1:0] result;
    logic                   controlArr;
    logic                   controlArrWEnable_a;
    logic [AW-1:0]          controlArrAddr_a;
    logic signed [DW-1:0]   controlArrWData_a;
    logic signed [DW-1:0]   controlArrRData_a;
    logic                   controlArrWEnable_b;
    logic [AW-1:0]          controlArrAddr_b;
    logic signed [DW-1:0]   controlArrWData_b;
    logic signed [DW-1:0]   controlArrRData_b;

    modport master (
        output r_enable, init_i, init_acc, controlArr,
               controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
               controlArrWEnable_b, controlArrAddr_b, controlArrWData_b,
        input  w_enable, result, controlArrRData_a, controlArrRData_b
    );
    modport slave (
        input  r_enable, init_i, init_acc, controlArr,
               controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
               controlArrWEnable_b, controlArrAddr_b, controlArrWData_b,
        output w_enable, result, controlArrRData_a, controlArrRData_b
    );
endinterface

// File: rtl/dot_prod_engine.sv
// Dot-product engine: two host-loadable signed memories, result = init_acc + sum a[k]*b[k].
// Define DOTPROD_MUL_PIPE_EN to register the product before the accumulator (+1 cycle latency).
module dot_prod_engine #(
    parameter int N    = 1000,
    parameter int AW   = 10,
    parameter int DW   = 27,
    parameter int ACCW = 64
) (
    input logic       clk,
    input logic       rst_n,
    dot_prod_if.slave bus
);
    localparam int PW = 2 * DW;
`ifdef DOTPROD_MUL_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [AW-1:0]          idx;
    logic signed [ACCW-1:0] acc;
    logic signed [DW-1:0]   mem_a [2**AW];
    logic signed [DW-1:0]   mem_b [2**AW];
    logic signed [DW-1:0]   rd_a, rd_b;
    logic                   rd_host;
    logic                   idle, issue, start, drain_last;
    logic [AW-1:0]          addr_a, addr_b;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext, acc_in;
    logic [STAGES:1]        vld_pipe, vld_next;

    assign idle  = (state == IDLE);
    assign issue = (state == RUN);
    assign start = idle && bus.r_enable && !bus.controlArr;

    // Single port per memory: host owns the address in IDLE, engine otherwise.
    assign addr_a = idle ? bus.controlArrAddr_a : idx;
    assign addr_b = idle ? bus.controlArrAddr_b : idx;

    always_ff @(posedge clk) begin
        if (idle && bus.controlArr && bus.controlArrWEnable_a)
            mem_a[bus.controlArrAddr_a] <= bus.controlArrWData_a;
        if (idle && bus.controlArr && bus.controlArrWEnable_b)
            mem_b[bus.controlArrAddr_b] <= bus.controlArrWData_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a    <= '0;
            rd_b    <= '0;
            rd_host <= 1'b0;
        end else begin
            rd_a    <= mem_a[addr_a];
            rd_b    <= mem_b[addr_b];
            rd_host <= idle;
        end
    end

    // Host only ever sees data that was fetched on its own address.
    assign bus.controlArrRData_a = (idle && rd_host) ? rd_a : '0;
    assign bus.controlArrRData_b = (idle && rd_host) ? rd_b : '0;

    assign prod     = PW'(rd_a) * PW'(rd_b);
    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

`ifdef DOTPROD_MUL_PIPE_EN
    logic signed [ACCW-1:0] prod_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod_q <= '0;
        else        prod_q <= prod_ext;
    end
    assign acc_in     = prod_q;
    assign vld_next   = {vld_pipe[1], issue};
    assign drain_last = !vld_pipe[1];
`else
    assign acc_in     = prod_ext;
    assign vld_next   = issue;
    assign drain_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            vld_pipe     <= '0;
            bus.w_enable <= 1'b0;
            bus.result   <= '0;
        end else begin
            bus.w_enable <= 1'b0;
            vld_pipe     <= vld_next;
            if (vld_pipe[STAGES]) acc <= acc + acc_in;
            case (state)
                IDLE: if (start) begin
                    idx   <= bus.init_i;
                    acc   <= bus.init_acc;
                    state <= (32'(bus.init_i) >= N) ? DONE : RUN;
                end
                RUN: begin
                    if (idx == AW'(N - 1)) state <= DRAIN;
                    else                   idx   <= idx + 1'b1;
                end
                DRAIN: if (drain_last) state <= DONE;
                DONE: begin
                    bus.w_enable <= 1'b1;
                    bus.result   <= acc;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_prod_engine.sv
// Randomised self-checking bench for dot_prod_engine against an array-based sum model.
module tb_dot_prod_engine;
    localparam int N = 1000, AW = 10, DW = 27, ACCW = 64;
`ifdef DOTPROD_MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ma [2**AW];
    int   mb [2**AW];

    dot_prod_if #(.AW(AW), .DW(DW), .ACCW(ACCW)) bus ();
    dot_prod_engine #(.N(N), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic longint model(input int ii, input longint ia);
        longint s = ia;
        for (int k = ii; k < N; k++) s += longint'(ma[k]) * longint'(mb[k]);
        return s;
    endfunction

    function automatic int rnd_elem();
        return int'($urandom_range(32'h07FF_FFFF, 0)) - (1 << 26);
    endfunction

    task automatic host_idle();
        @(negedge clk);
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrWEnable_b = 1'b0;
        bus.controlArr = 1'b0;
    endtask

    task automatic write_ab(input int k, input int va, input int vb);
        @(negedge clk);
        bus.controlArr = 1'b1;
        bus.controlArrWEnable_a = 1'b1;
        bus.controlArrWEnable_b = 1'b1;
        bus.controlArrAddr_a = k[AW-1:0];
        bus.controlArrAddr_b = k[AW-1:0];
        bus.controlArrWData_a = va[DW-1:0];
        bus.controlArrWData_b = vb[DW-1:0];
        ma[k] = va;
        mb[k] = vb;
    endtask

    task automatic host_read(input int k, output int ra, output int rb);
        @(negedge clk);
        bus.controlArr = 1'b1;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrWEnable_b = 1'b0;
        bus.controlArrAddr_a = k[AW-1:0];
        bus.controlArrAddr_b = k[AW-1:0];
        @(negedge clk);
        ra = int'(bus.controlArrRData_a);
        rb = int'(bus.controlArrRData_b);
    endtask

    // Start at the next edge (cycle 0) and watch w_enable for a bounded window.
    task automatic run(input int ii, input longint ia, output int lat, output longint res,
                       output int pulses);
        @(negedge clk);
        bus.controlArr = 1'b0;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrWEnable_b = 1'b0;
        bus.r_enable = 1'b1;
        bus.init_i = ii[AW-1:0];
        bus.init_acc = ia;
        @(negedge clk);
        bus.r_enable = 1'b0;
        lat = -1;
        res = 0;
        pulses = 0;
        for (int c = 0; c < N + 20; c++) begin
            if (bus.w_enable) begin
                pulses++;
                if (lat < 0) begin lat = c; res = bus.result; end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int ii, input longint ia,
                             input longint exp_res);
        int lat, pulses;
        longint res;
        run(ii, ia, lat, res, pulses);
        checks++;
        if (lat !== (N > ii ? N - ii : 0) + (N > ii ? LAT : 1)) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat,
                     (N > ii ? N - ii : 0) + (N > ii ? LAT : 1));
        end
        checks++;
        if (res !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %0d expected %0d", name, res, exp_res);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL %s pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (bus.result !== exp_res) begin
            failures++;
            $display("FAIL %s result_held: got %0d expected %0d", name, bus.result, exp_res);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.w_enable !== 1'b0 || bus.result !== 64'sd0) begin
            failures++;
            $display("FAIL reset_outputs: got w=%0b r=%0d expected 0/0", bus.w_enable, bus.result);
        end
        checks++;
        if (bus.controlArrRData_a !== '0 || bus.controlArrRData_b !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %0d/%0d expected 0/0",
                     bus.controlArrRData_a, bus.controlArrRData_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.w_enable !== 1'b0 || bus.result !== 64'sd0) begin
            failures++;
            $display("FAIL post_reset_idle: got w=%0b r=%0d expected 0/0", bus.w_enable, bus.result);
        end
    endtask

    task automatic test_ramp();
        for (int k = 0; k < N; k++) write_ab(k, k + 1, 2);
        host_idle();
        check_run("ramp", 0, 0, 64'sd1001000);
    endtask

    task automatic test_random();
        for (int k = 0; k < N; k++) write_ab(k, rnd_elem(), rnd_elem());
        host_idle();
        check_run("random_full", 0, 0, model(0, 0));
        begin
            int ii = int'($urandom_range(N - 1, 0));
            longint ia = {$urandom, $urandom};
            check_run("random_offset", ii, ia, model(ii, ia));
        end
    endtask

    task automatic test_wrap();
        longint ia = 64'h7FFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < N; k++) write_ab(k, -(1 << 26), -(1 << 26));
        host_idle();
        // 1000 * 2**52 added to INT64_MAX: expected value wraps negative
        check_run("wrap", 0, ia, ia + 64'sd1000 * (64'sd1 << 52));
    endtask

    task automatic test_tail();
        longint ia = {$urandom, $urandom};
        for (int k = 997; k < N; k++) write_ab(k, 3, 4);
        host_idle();
        check_run("tail3", 997, 5, 64'sd41);
        check_run("empty", 1000, ia, ia);
    endtask

    task automatic test_host();
        int x = rnd_elem(), y = rnd_elem(), ra, rb;
        write_ab(1023, x, -x);
        write_ab(1023, y, -y);
        @(negedge clk);
        ra = int'(bus.controlArrRData_a);
        rb = int'(bus.controlArrRData_b);
        checks++;
        if (ra !== x || rb !== -x) begin
            failures++;
            $display("FAIL read_before_write: got %0d/%0d expected %0d/%0d", ra, rb, x, -x);
        end
        host_read(1023, ra, rb);
        checks++;
        if (ra !== y || rb !== -y) begin
            failures++;
            $display("FAIL host_readback: got %0d/%0d expected %0d/%0d", ra, rb, y, -y);
        end
        host_idle();
    endtask

    task automatic test_busy();
        int lat = -1, pulses = 0, ra, rb;
        longint res = 0, exp_res;
        for (int k = 0; k < N; k++) write_ab(k, rnd_elem(), rnd_elem());
        host_idle();
        exp_res = model(0, 0);
        @(negedge clk);
        bus.r_enable = 1'b1;
        bus.init_i = '0;
        bus.init_acc = 0;
        @(negedge clk);
        bus.r_enable = 1'b0;
        for (int c = 0; c < N + 20; c++) begin
            if (bus.w_enable) begin
                pulses++;
                if (lat < 0) begin lat = c; res = bus.result; end
            end
            if (c >= 2 && c <= 21) begin
                checks++;
                if (bus.controlArrRData_a !== '0 || bus.controlArrRData_b !== '0) begin
                    failures++;
                    $display("FAIL busy_rdata c=%0d: got %0d/%0d expected 0/0", c,
                             bus.controlArrRData_a, bus.controlArrRData_b);
                end
            end
            @(negedge clk);
            bus.controlArr = (c >= 1 && c <= 20);
            bus.controlArrWEnable_a = (c >= 1 && c <= 20);
            bus.controlArrWEnable_b = (c >= 1 && c <= 20);
            bus.controlArrAddr_a = AW'(c);
            bus.controlArrAddr_b = AW'(c);
            bus.controlArrWData_a = DW'($urandom);
            bus.controlArrWData_b = DW'($urandom);
            bus.r_enable = (c >= 21 && c <= 30);
        end
        bus.r_enable = 1'b0;
        host_idle();
        checks++;
        if (lat !== N + LAT || pulses !== 1) begin
            failures++;
            $display("FAIL busy_done: got lat=%0d pulses=%0d expected %0d/1", lat, pulses, N + LAT);
        end
        checks++;
        if (res !== exp_res) begin
            failures++;
            $display("FAIL busy_result: got %0d expected %0d", res, exp_res);
        end
        for (int k = 1; k <= 20; k += 6) begin
            host_read(k, ra, rb);
            checks++;
            if (ra !== ma[k] || rb !== mb[k]) begin
                failures++;
                $display("FAIL busy_mem[%0d]: got %0d/%0d expected %0d/%0d", k, ra, rb, ma[k], mb[k]);
            end
        end
        host_idle();
    endtask

    task automatic test_ignore_ctrl();
        int pulses = 0;
        @(negedge clk);
        bus.controlArr = 1'b1;
        bus.r_enable = 1'b1;
        bus.init_i = AW'(1000);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.w_enable) pulses++;
        end
        bus.r_enable = 1'b0;
        host_idle();
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL ctrl_start_ignored: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, ra, rb;
        @(negedge clk);
        bus.r_enable = 1'b1;
        bus.init_i = '0;
        bus.init_acc = 64'sd77;
        @(negedge clk);
        bus.r_enable = 1'b0;
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.w_enable !== 1'b0 || bus.result !== 64'sd0) begin
            failures++;
            $display("FAIL midrun_reset: got w=%0b r=%0d expected 0/0", bus.w_enable, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N + 10; c++) begin
            @(negedge clk);
            if (bus.w_enable) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL aborted_no_done: got %0d pulses expected 0", pulses);
        end
        for (int k = 0; k < N; k += 333) begin
            host_read(k, ra, rb);
            checks++;
            if (ra !== ma[k] || rb !== mb[k]) begin
                failures++;
                $display("FAIL mem_after_reset[%0d]: got %0d/%0d expected %0d/%0d",
                         k, ra, rb, ma[k], mb[k]);
            end
        end
        host_idle();
        check_run("restart", 0, 64'sd77, model(0, 64'sd77));
    endtask

    initial begin
        bus.r_enable = 1'b0;
        bus.init_i = '0;
        bus.init_acc = '0;
        bus.controlArr = 1'b0;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrAddr_a = '0;
        bus.controlArrWData_a = '0;
        bus.controlArrWEnable_b = 1'b0;
        bus.controlArrAddr_b = '0;
        bus.controlArrWData_b = '0;
        test_reset();
        test_ramp();
        test_random();
        test_wrap();
        test_tail();
        test_host();
        test_busy();
        test_ignore_ctrl();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
